// File: rtl/mips_exec_pkg.sv
// Shared constants for the MIPS decode/execute slice: opcodes, functs,
// ALU operation codes and control-word bit positions.
package mips_exec_pkg;

  localparam int DATA_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_NOR  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam int REGDST   = 0;
  localparam int BRANCH   = 1;
  localparam int MEMREAD  = 2;
  localparam int MEMTOREG = 3;
  localparam int MEMWRITE = 4;
  localparam int ALUSRC   = 5;
  localparam int REGWRITE = 6;

endpackage

// File: rtl/mips_alu32.sv
// Combinational 32-bit ALU: logic ops, wrapping add/sub, signed and
// unsigned set-less-than, plus a zero flag on the result.
module mips_alu32
  import mips_exec_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

  always_comb begin
    result = '0;
    case (op)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mips_exec_stage.sv
// Decode/extend/execute slice: decodes the instruction, extends the
// immediate, runs the ALU and registers every result once per clock.
module mips_exec_stage
  import mips_exec_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] instruction,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  output logic [6:0]        signals,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] imm_ext,
  output logic [4:0]        write_reg,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero
);

  logic [5:0]        op_p0;
  logic [5:0]        funct_p0;
  logic [4:0]        rt_p0;
  logic [4:0]        rd_p0;
  logic [15:0]       imm_p0;
  logic [6:0]        ctrl_p0;
  logic [2:0]        alu_op_p0;
  logic              ext_zero_p0;
  logic [DATA_W-1:0] imm_ext_p0;
  logic [DATA_W-1:0] alu_b_p0;
  logic [4:0]        write_reg_p0;
  logic [DATA_W-1:0] alu_result_p0;
  logic              zero_p0;
  logic              unused_fields;

  logic [6:0]        signals_p1;
  logic [2:0]        alu_op_p1;
  logic [DATA_W-1:0] imm_ext_p1;
  logic [4:0]        write_reg_p1;
  logic [DATA_W-1:0] alu_result_p1;
  logic              zero_p1;

  // Stage p0: field split, decode, extension, operand select, ALU
  assign op_p0    = instruction[31:26];
  assign rt_p0    = instruction[20:16];
  assign rd_p0    = instruction[15:11];
  assign funct_p0 = instruction[5:0];
  assign imm_p0   = instruction[15:0];
  assign unused_fields = ^{instruction[25:21], instruction[10:6]};

  always_comb begin
    ctrl_p0     = '0;
    alu_op_p0   = ALU_ADD;
    ext_zero_p0 = 1'b0;
    case (op_p0)
      OP_RTYPE: begin
        ctrl_p0[REGDST]   = 1'b1;
        ctrl_p0[REGWRITE] = 1'b1;
        case (funct_p0)
          FN_ADD, FN_ADDU: alu_op_p0 = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op_p0 = ALU_SUB;
          FN_AND:          alu_op_p0 = ALU_AND;
          FN_OR:           alu_op_p0 = ALU_OR;
          FN_XOR:          alu_op_p0 = ALU_XOR;
          FN_NOR:          alu_op_p0 = ALU_NOR;
          FN_SLT:          alu_op_p0 = ALU_SLT;
          FN_SLTU:         alu_op_p0 = ALU_SLTU;
          // Unrecognised funct keeps the destination select but never writes back
          default:         ctrl_p0[REGWRITE] = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl_p0[ALUSRC]   = 1'b1;
        ctrl_p0[REGWRITE] = 1'b1;
      end
      OP_SLTI: begin
        ctrl_p0[ALUSRC]   = 1'b1;
        ctrl_p0[REGWRITE] = 1'b1;
        alu_op_p0         = ALU_SLT;
      end
      OP_SLTIU: begin
        ctrl_p0[ALUSRC]   = 1'b1;
        ctrl_p0[REGWRITE] = 1'b1;
        alu_op_p0         = ALU_SLTU;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl_p0[ALUSRC]   = 1'b1;
        ctrl_p0[REGWRITE] = 1'b1;
        ext_zero_p0       = 1'b1;
        alu_op_p0         = (op_p0 == OP_ANDI) ? ALU_AND :
                            (op_p0 == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_LW: begin
        ctrl_p0[ALUSRC]   = 1'b1;
        ctrl_p0[MEMREAD]  = 1'b1;
        ctrl_p0[MEMTOREG] = 1'b1;
        ctrl_p0[REGWRITE] = 1'b1;
      end
      OP_SW: begin
        ctrl_p0[ALUSRC]   = 1'b1;
        ctrl_p0[MEMWRITE] = 1'b1;
      end
      OP_BEQ: begin
        ctrl_p0[BRANCH] = 1'b1;
        alu_op_p0       = ALU_SUB;
      end
      default: ctrl_p0 = '0;
    endcase
  end

  assign imm_ext_p0   = ext_zero_p0 ? {16'h0000, imm_p0} : {{16{imm_p0[15]}}, imm_p0};
  assign alu_b_p0     = ctrl_p0[ALUSRC] ? imm_ext_p0 : read_data_2;
  assign write_reg_p0 = ctrl_p0[REGDST] ? rd_p0 : rt_p0;

  mips_alu32 u_alu (
    .a      (read_data_1),
    .b      (alu_b_p0),
    .op     (alu_op_p0),
    .result (alu_result_p0),
    .zero   (zero_p0)
  );

  // Stage p1: output registers; reset clears everything including zero
  always_ff @(posedge clock) begin
    if (reset) begin
      signals_p1    <= '0;
      alu_op_p1     <= '0;
      imm_ext_p1    <= '0;
      write_reg_p1  <= '0;
      alu_result_p1 <= '0;
      zero_p1       <= 1'b0;
    end else begin
      signals_p1    <= ctrl_p0;
      alu_op_p1     <= alu_op_p0;
      imm_ext_p1    <= imm_ext_p0;
      write_reg_p1  <= write_reg_p0;
      alu_result_p1 <= alu_result_p0;
      zero_p1       <= zero_p0;
    end
  end

  assign signals    = signals_p1;
  assign alu_op     = alu_op_p1;
  assign imm_ext    = imm_ext_p1;
  assign write_reg  = write_reg_p1;
  assign alu_result = alu_result_p1;
  assign zero       = zero_p1;

endmodule

// File: tb/tb_mips_exec_stage.sv
// Self-checking bench for mips_exec_stage: directed cases then random
// instructions compared against an instruction-level reference model.
module tb_mips_exec_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = '0;
  logic [31:0] read_data_1 = '0;
  logic [31:0] read_data_2 = '0;
  logic [6:0]  signals;
  logic [2:0]  alu_op;
  logic [31:0] imm_ext;
  logic [4:0]  write_reg;
  logic [31:0] alu_result;
  logic        zero;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [6:0]  sig;
    logic [2:0]  op;
    logic [31:0] imm;
    logic [4:0]  wr;
    logic [31:0] res;
    logic        z;
  } exp_t;

  mips_exec_stage dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2),
    .signals     (signals),
    .alu_op      (alu_op),
    .imm_ext     (imm_ext),
    .write_reg   (write_reg),
    .alu_result  (alu_result),
    .zero        (zero)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h expected=%08h (instr=%08h a=%08h b=%08h)",
               tag, got, exp, instruction, read_data_1, read_data_2);
    end
  endtask

  // Instruction-level model: what each instruction computes, by name
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] sx, zx;
    logic [5:0] opc, fn;
    opc = ins[31:26];
    fn  = ins[5:0];
    sx  = {{16{ins[15]}}, ins[15:0]};
    zx  = {16'h0, ins[15:0]};
    e.imm = sx;
    e.wr  = ins[20:16];
    e.sig = 7'h00;
    e.op  = 3'd2;
    e.res = a + b;
    case (opc)
      6'h00: begin
        e.sig = 7'h41;
        e.wr  = ins[15:11];
        case (fn)
          6'h20, 6'h21: begin e.op = 3'd2; e.res = a + b; end
          6'h22, 6'h23: begin e.op = 3'd6; e.res = a - b; end
          6'h24: begin e.op = 3'd0; e.res = a & b; end
          6'h25: begin e.op = 3'd1; e.res = a | b; end
          6'h26: begin e.op = 3'd3; e.res = a ^ b; end
          6'h27: begin e.op = 3'd4; e.res = ~(a | b); end
          6'h2A: begin e.op = 3'd7; e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
          6'h2B: begin e.op = 3'd5; e.res = (a < b) ? 32'd1 : 32'd0; end
          default: begin e.sig = 7'h01; e.op = 3'd2; e.res = a + b; end
        endcase
      end
      6'h08, 6'h09: begin e.sig = 7'h60; e.op = 3'd2; e.res = a + sx; end
      6'h0A: begin e.sig = 7'h60; e.op = 3'd7; e.res = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0; end
      6'h0B: begin e.sig = 7'h60; e.op = 3'd5; e.res = (a < sx) ? 32'd1 : 32'd0; end
      6'h0C: begin e.sig = 7'h60; e.op = 3'd0; e.imm = zx; e.res = a & zx; end
      6'h0D: begin e.sig = 7'h60; e.op = 3'd1; e.imm = zx; e.res = a | zx; end
      6'h0E: begin e.sig = 7'h60; e.op = 3'd3; e.imm = zx; e.res = a ^ zx; end
      6'h23: begin e.sig = 7'h6C; e.op = 3'd2; e.res = a + sx; end
      6'h2B: begin e.sig = 7'h30; e.op = 3'd2; e.res = a + sx; end
      6'h04: begin e.sig = 7'h02; e.op = 3'd6; e.res = a - b; end
      default: ;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd);
    return {6'h00, 5'd1, 5'd2, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [15:0] imm);
    return {opc, 5'd1, 5'd4, imm};
  endfunction

  task automatic check_all(input string tag, input exp_t e);
    check_eq({tag, ".signals"},   {25'd0, signals},   {25'd0, e.sig});
    check_eq({tag, ".alu_op"},    {29'd0, alu_op},    {29'd0, e.op});
    check_eq({tag, ".imm_ext"},   imm_ext,            e.imm);
    check_eq({tag, ".write_reg"}, {27'd0, write_reg}, {27'd0, e.wr});
    check_eq({tag, ".result"},    alu_result,         e.res);
    check_eq({tag, ".zero"},      {31'd0, zero},      {31'd0, e.z});
  endtask

  task automatic apply(input string tag, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    reset = 1'b0;
    instruction = ins;
    read_data_1 = a;
    read_data_2 = b;
    e = model(ins, a, b);
    @(posedge clock);
    #1;
    check_all(tag, e);
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    instruction = $urandom;
    read_data_1 = $urandom;
    read_data_2 = $urandom;
    @(posedge clock);
    #1;
    check_all(tag, '0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] op_tab [12] = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                              6'h0E, 6'h23, 6'h2B, 6'h04, 6'h3F};
  logic [5:0] fn_tab [11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                              6'h27, 6'h2A, 6'h2B, 6'h00};

  initial begin
    logic [31:0] ins, a, b;
    apply_reset("reset");
    apply_reset("reset2");

    apply("add",    32'h0022_1820, 32'd5, 32'd7);
    apply("slt",    rtype(6'h2A, 5'd8), 32'hFFFF_FFFF, 32'd1);
    apply("sltu",   rtype(6'h2B, 5'd9), 32'hFFFF_FFFF, 32'd1);
    apply("addi",   itype(6'h08, 16'h8000), 32'd0, 32'd3);
    apply("ori",    itype(6'h0D, 16'h8000), 32'h0001_0000, 32'd3);
    apply("lw",     itype(6'h23, 16'h0004), 32'h0000_0100, 32'd0);
    apply("sw",     itype(6'h2B, 16'hFFFC), 32'h0000_0100, 32'd0);
    apply("beq",    itype(6'h04, 16'h0010), 32'd9, 32'd9);
    apply("bne_eq", itype(6'h04, 16'h0010), 32'd9, 32'd8);
    apply("ovf",    rtype(6'h20, 5'd3), 32'h7FFF_FFFF, 32'd1);
    apply("unk_op", itype(6'h3F, 16'h1234), 32'd1, 32'd2);
    apply("unk_fn", rtype(6'h3E, 5'd7), 32'd1, 32'd2);
    apply("sltiu",  itype(6'h0B, 16'hFFFF), 32'hFFFF_FFFE, 32'd0);
    apply_reset("reset_mid");
    apply("resume", rtype(6'h22, 5'd5), 32'd10, 32'd10);

    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      ins[31:26] = op_tab[$urandom_range(0, 11)];
      if (ins[31:26] == 6'h00 && $urandom_range(0, 9) != 0)
        ins[5:0] = fn_tab[$urandom_range(0, 10)];
      a = pick_operand();
      b = ($urandom_range(0, 4) == 0) ? a : pick_operand();
      if ($urandom_range(0, 24) == 0) apply_reset("rnd_reset");
      else apply("rnd", ins, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
